mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter for a single memory target port.
//
// Optional feature: define MEM_ARB_RD_TIMEOUT_EN to enable the read watchdog.
// With it, a read waiting TIMEOUT_CYCLES cycles without data is completed
// with an err + rd_valid pulse and zero data. Without it, o_reqN_err is
// tied to 0 and RD_WAIT waits indefinitely.
//
// Ports:
//   i_clk_ahb, i_rst_ahb             clock, synchronous active-high reset
//   i_reqN_* / o_reqN_* (N=0,1)      requester request, accept, read return, error
//   o_tgt_* / i_tgt_*                target request, accept and read return
module mem_port_arbiter #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  i_clk_ahb,
   input  logic                  i_rst_ahb,

   input  logic                  i_req0_valid,
   input  logic                  i_req0_rd0_wr1,
   input  logic [ADDR_WIDTH-1:0] i_req0_addr,
   input  logic [DATA_WIDTH-1:0] i_req0_wr_data,
   output logic                  o_req0_ready,
   output logic                  o_req0_rd_valid,
   output logic [DATA_WIDTH-1:0] o_req0_rd_data,
   output logic                  o_req0_err,

   input  logic                  i_req1_valid,
   input  logic                  i_req1_rd0_wr1,
   input  logic [ADDR_WIDTH-1:0] i_req1_addr,
   input  logic [DATA_WIDTH-1:0] i_req1_wr_data,
   output logic                  o_req1_ready,
   output logic                  o_req1_rd_valid,
   output logic [DATA_WIDTH-1:0] o_req1_rd_data,
   output logic                  o_req1_err,

   output logic                  o_tgt_valid,
   output logic                  o_tgt_rd0_wr1,
   output logic [ADDR_WIDTH-1:0] o_tgt_addr,
   output logic [DATA_WIDTH-1:0] o_tgt_wr_data,
   input  logic                  i_tgt_ready,
   input  logic                  i_tgt_rd_valid,
   input  logic [DATA_WIDTH-1:0] i_tgt_rd_data
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RD_WAIT = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic   gnt_q, gnt_d;
   logic   rr_q, rr_d;
   logic   timeout_c;

   // Fields of the currently granted requester
   logic                  sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wr_data;

   assign sel_wr      = gnt_q ? i_req1_rd0_wr1 : i_req0_rd0_wr1;
   assign sel_addr    = gnt_q ? i_req1_addr    : i_req0_addr;
   assign sel_wr_data = gnt_q ? i_req1_wr_data : i_req0_wr_data;

`ifdef MEM_ARB_RD_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_q, wd_d;

   // Watchdog: zero outside RD_WAIT so it is clear on entry, counts RD_WAIT cycles
   always_comb begin
      wd_d = '0;
      if (state_q == RD_WAIT) begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   assign timeout_c = (state_q == RD_WAIT) && !i_tgt_rd_valid &&
                      (wd_q == WD_W'(TIMEOUT_CYCLES));

   always_ff @(posedge i_clk_ahb) begin
      if (i_rst_ahb) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign timeout_c          = 1'b0;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

   // Next-state, grant owner and round-robin pointer
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      rr_d    = rr_q;
      case (state_q)
         IDLE: begin
            if (i_req0_valid || i_req1_valid) begin
               gnt_d   = (i_req0_valid && i_req1_valid) ? rr_q : i_req1_valid;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // Requests are held until accepted, so no re-arbitration here
            if (i_tgt_ready) begin
               rr_d    = ~gnt_q;
               state_d = sel_wr ? IDLE : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (i_tgt_rd_valid || timeout_c) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk_ahb) begin
      if (i_rst_ahb) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
      end
   end

   // Outputs; all forced low while reset is asserted so a pending
   // transaction is dropped without any ready/rd_valid/err pulse
   always_comb begin
      o_tgt_valid     = 1'b0;
      o_tgt_rd0_wr1   = 1'b0;
      o_tgt_addr      = '0;
      o_tgt_wr_data   = '0;
      o_req0_ready    = 1'b0;
      o_req1_ready    = 1'b0;
      o_req0_rd_valid = 1'b0;
      o_req1_rd_valid = 1'b0;
      o_req0_rd_data  = '0;
      o_req1_rd_data  = '0;
      o_req0_err      = 1'b0;
      o_req1_err      = 1'b0;
      if (!i_rst_ahb) begin
         if (state_q == GRANT) begin
            o_tgt_valid   = 1'b1;
            o_tgt_rd0_wr1 = sel_wr;
            o_tgt_addr    = sel_addr;
            o_tgt_wr_data = sel_wr_data;
            o_req0_ready  = i_tgt_ready && !gnt_q;
            o_req1_ready  = i_tgt_ready &&  gnt_q;
         end
         // A timeout completes the read with zero data
         if ((state_q == RD_WAIT) && (i_tgt_rd_valid || timeout_c)) begin
            if (gnt_q) begin
               o_req1_rd_valid = 1'b1;
               o_req1_rd_data  = i_tgt_rd_valid ? i_tgt_rd_data : '0;
               o_req1_err      = timeout_c;
            end else begin
               o_req0_rd_valid = 1'b1;
               o_req0_rd_data  = i_tgt_rd_valid ? i_tgt_rd_data : '0;
               o_req0_err      = timeout_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter.
// Stimulus pushes expected target acceptances and read returns into a queue;
// a negedge monitor pops and compares whenever the DUT shows one.
module tb_mem_port_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          r0_valid = 1'b0, r0_wr = 1'b0;
   logic [AW-1:0] r0_addr = '0;
   logic [DW-1:0] r0_wdata = '0;
   logic          r1_valid = 1'b0, r1_wr = 1'b0;
   logic [AW-1:0] r1_addr = '0;
   logic [DW-1:0] r1_wdata = '0;
   logic          t_ready = 1'b0, t_rd_valid = 1'b0;
   logic [DW-1:0] t_rd_data = '0;

   logic          o0_ready, o0_rd_valid, o0_err;
   logic          o1_ready, o1_rd_valid, o1_err;
   logic [DW-1:0] o0_rd_data, o1_rd_data;
   logic          ot_valid, ot_wr;
   logic [AW-1:0] ot_addr;
   logic [DW-1:0] ot_wdata;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic          rd;    // 0 = target acceptance, 1 = read return
      logic          port;
      logic          wr;
      logic          err;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ev_t;

   ev_t exp_q[$];

   mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
      .i_clk_ahb(clk), .i_rst_ahb(rst),
      .i_req0_valid(r0_valid), .i_req0_rd0_wr1(r0_wr), .i_req0_addr(r0_addr),
      .i_req0_wr_data(r0_wdata), .o_req0_ready(o0_ready), .o_req0_rd_valid(o0_rd_valid),
      .o_req0_rd_data(o0_rd_data), .o_req0_err(o0_err),
      .i_req1_valid(r1_valid), .i_req1_rd0_wr1(r1_wr), .i_req1_addr(r1_addr),
      .i_req1_wr_data(r1_wdata), .o_req1_ready(o1_ready), .o_req1_rd_valid(o1_rd_valid),
      .o_req1_rd_data(o1_rd_data), .o_req1_err(o1_err),
      .o_tgt_valid(ot_valid), .o_tgt_rd0_wr1(ot_wr), .o_tgt_addr(ot_addr),
      .o_tgt_wr_data(ot_wdata), .i_tgt_ready(t_ready), .i_tgt_rd_valid(t_rd_valid),
      .i_tgt_rd_data(t_rd_data)
   );

   always #5 clk = ~clk;

   function automatic ev_t mk(input logic rd, input logic port, input logic wr,
                              input logic err, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data);
      ev_t e;
      e.rd = rd; e.port = port; e.wr = wr; e.err = err; e.addr = addr; e.data = data;
      return e;
   endfunction

   function automatic logic any_out();
      return |{o0_ready, o0_rd_valid, o0_err, o0_rd_data, o1_ready, o1_rd_valid,
               o1_err, o1_rd_data, ot_valid, ot_wr, ot_addr, ot_wdata};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_compare(input string name, input ev_t act);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s unexpected actual=%h", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, e);
         end
      end
   endtask

   // Monitor: compares every acceptance / read return against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (o0_ready || o1_ready) begin
            if (o0_ready && o1_ready) begin
               checks++; errors++;
               $display("FAIL both_ready actual=11 required=one-hot");
            end
            sb_compare("accept", mk(1'b0, o1_ready, ot_wr, 1'b0, ot_addr, ot_wdata));
         end
         if (o0_rd_valid || o1_rd_valid) begin
            if (o0_rd_valid && o1_rd_valid) begin
               checks++; errors++;
               $display("FAIL both_rd_valid actual=11 required=one-hot");
            end
            sb_compare("rd_return", o1_rd_valid ?
                       mk(1'b1, 1'b1, 1'b0, o1_err, '0, o1_rd_data) :
                       mk(1'b1, 1'b0, 1'b0, o0_err, '0, o0_rd_data));
         end
         if (!o0_rd_valid) chk("rd_data0_zero", 64'(o0_rd_data), 64'd0);
         if (!o1_rd_valid) chk("rd_data1_zero", 64'(o1_rd_data), 64'd0);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   logic [AW-1:0] a0 [2];
   logic [AW-1:0] a1 [2];
   logic [DW-1:0] d0 [2];
   logic [DW-1:0] d1 [2];

   initial begin
      // Reset: outputs low even with a request pending
      r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = 32'h4; t_ready = 1'b1;
      @(negedge clk);
      chk("reset_outs", 64'(any_out()), 64'd0);
      step();
      r0_valid = 1'b0; t_ready = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outs", 64'(any_out()), 64'd0);

      // Single write from req0
      step();
      r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = 32'h10; r0_wdata = 32'hA5A5A5A5; t_ready = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hA5A5A5A5));
      @(negedge clk);
      chk("wr_latency_idle", 64'(ot_valid), 64'd0);
      step();
      @(negedge clk);
      chk("wr_tgt_valid", 64'(ot_valid), 64'd1);
      chk("wr_tgt_addr", 64'(ot_addr), 64'h10);
      chk("wr_req0_ready", 64'(o0_ready), 64'd1);
      chk("wr_req1_ready", 64'(o1_ready), 64'd0);
      step();
      r0_valid = 1'b0;
      @(negedge clk);
      chk("wr_back_idle", 64'(ot_valid), 64'd0);

      // Both requesters streaming writes from reset: grants 0,1,0,1
      do_reset();
      a0[0] = 32'h100; a0[1] = 32'h104; d0[0] = 32'h0000_0A00; d0[1] = 32'h0000_0A01;
      a1[0] = 32'h200; a1[1] = 32'h204; d1[0] = 32'h0000_0B00; d1[1] = 32'h0000_0B01;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, a0[i], d0[i]));
         exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, a1[i], d1[i]));
      end
      begin
         int n0, n1, cyc;
         logic s0, s1;
         n0 = 0; n1 = 0; cyc = 0;
         r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = a0[0]; r0_wdata = d0[0];
         r1_valid = 1'b1; r1_wr = 1'b1; r1_addr = a1[0]; r1_wdata = d1[0];
         t_ready = 1'b1;
         while ((n0 < 2 || n1 < 2) && cyc < 40) begin
            @(negedge clk);
            s0 = o0_ready; s1 = o1_ready;
            step();
            cyc++;
            if (s0) begin
               n0++;
               if (n0 < 2) begin r0_addr = a0[n0]; r0_wdata = d0[n0]; end
               else r0_valid = 1'b0;
            end
            if (s1) begin
               n1++;
               if (n1 < 2) begin r1_addr = a1[n1]; r1_wdata = d1[n1]; end
               else r1_valid = 1'b0;
            end
         end
         chk("rr_done_in_budget", 64'(cyc < 40), 64'd1);
      end
      r0_valid = 1'b0; r1_valid = 1'b0; t_ready = 1'b0;

      // req1 read with 3 cycles of target backpressure, data 2 cycles after accept
      step();
      r1_valid = 1'b1; r1_wr = 1'b0; r1_addr = 32'h40; r1_wdata = '0; t_ready = 1'b0;
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0));
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, '0, 32'h12345678));
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rd_stall_tgt_valid", 64'(ot_valid), 64'd1);
         chk("rd_stall_ready", 64'(o1_ready), 64'd0);
         step();
      end
      t_ready = 1'b1;
      @(negedge clk);
      chk("rd_ready_4th", 64'(o1_ready), 64'd1);
      step();
      r1_valid = 1'b0; t_ready = 1'b0;
      @(negedge clk);
      chk("rd_wait_no_valid", 64'(o1_rd_valid), 64'd0);
      chk("rd_wait_tgt_valid", 64'(ot_valid), 64'd0);
      step();
      t_rd_valid = 1'b1; t_rd_data = 32'h12345678;
      @(negedge clk);
      chk("rd_ret_valid1", 64'(o1_rd_valid), 64'd1);
      chk("rd_ret_valid0", 64'(o0_rd_valid), 64'd0);
      step();
      t_rd_valid = 1'b0;
      @(negedge clk);
      chk("rd_pulse_width", 64'(o1_rd_valid), 64'd0);

      // Stray read data in IDLE is ignored
      step();
      t_rd_valid = 1'b1; t_rd_data = 32'hDEADBEEF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("stray_rd_valid", 64'({o0_rd_valid, o1_rd_valid}), 64'd0);
         step();
      end
      t_rd_valid = 1'b0;

      // Reset while in RD_WAIT drops the read
      r0_valid = 1'b1; r0_wr = 1'b0; r0_addr = 32'h80; r0_wdata = '0; t_ready = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0));
      step();
      step();
      r0_valid = 1'b0; t_ready = 1'b0;
      rst = 1'b1; t_rd_valid = 1'b1; t_rd_data = 32'hCAFEF00D;
      @(negedge clk);
      chk("rst_rdwait_outs", 64'(any_out()), 64'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ignored", 64'(any_out()), 64'd0);
      step();
      t_rd_valid = 1'b0;

`ifdef MEM_ARB_RD_TIMEOUT_EN
      // Read never answered: err + rd_valid with zero data after 16 RD_WAIT cycles
      r0_valid = 1'b1; r0_wr = 1'b0; r0_addr = 32'hC0; r0_wdata = '0; t_ready = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hC0, 32'h0));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, '0, 32'h0));
      step();
      step();
      r0_valid = 1'b0; t_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("to_no_err_early", 64'(o0_err), 64'd0);
         step();
      end
      @(negedge clk);
      chk("to_err", 64'(o0_err), 64'd1);
      chk("to_rd_valid", 64'(o0_rd_valid), 64'd1);
      step();
      @(negedge clk);
      chk("to_back_idle", 64'(any_out()), 64'd0);
`endif

      step();
      step();
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
